seq_alu_engine: RTL and testbench
=================================

SEQ_ALU_ENGINE -- requirements
Module: seq_alu_engine

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports SHALL be as listed in REQ-002..REQ-012.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 in_valid  in  1  command present on a/b/op.
REQ-005 in_ready  out  1  block accepts a command this cycle.
REQ-006 a  in  4  operand A, unsigned.
REQ-007 b  in  4  operand B, unsigned.
REQ-008 op  in  3  opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not-A, 110 mul, 111 div.
REQ-009 out_valid  out  1  result/rem/div_by_zero valid.
REQ-010 out_ready  in  1  consumer takes the result.
REQ-011 result  out  8  operation result.
REQ-012 rem, div_by_zero, busy  out  4/1/1  division remainder; B==0 on div; state is CALC.

Function
REQ-013 FSM states SHALL be IDLE, CALC and DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 Accept SHALL occur at an edge where in_valid&in_ready; a, b and op SHALL be latched at that edge; unaccepted inputs SHALL be ignored.
REQ-015 Ops 000-101, and div with b==0, SHALL go IDLE->DONE at the accept edge; out_valid SHALL be high in the next cycle (latency 1).
REQ-016 Ops 110 and 111 with b!=0 SHALL go IDLE->CALC at the accept edge, perform one iteration per edge for exactly 4 edges (2-bit counter 0..3), and go CALC->DONE on the 4th; out_valid SHALL be high after accept edge +4.
REQ-017 Add/sub SHALL be computed at 8 bits on zero-extended operands; sub SHALL wrap two's complement (3-5 = 8'hFE); add max SHALL be 15+15 = 8'h1E.
REQ-018 And/or/xor SHALL zero-extend the 4-bit result; not-A SHALL give {4'h0, ~a}.
REQ-019 Mul SHALL be shift-add over the 4 bits of b, producing the exact 8-bit product.
REQ-020 Div SHALL be restoring division, one quotient bit per iteration MSB first; result = {4'h0, quotient}, rem = remainder.
REQ-021 Div with b==0 SHALL give result 8'hFF, rem 4'h0, div_by_zero 1; div_by_zero SHALL be 0 for every other completed command.
REQ-022 rem SHALL be 0 for every non-div op.
REQ-023 In DONE, result/rem/div_by_zero SHALL hold stable until out_valid&out_ready; that edge SHALL return to IDLE.
REQ-024 No new command SHALL be accepted in the cycle a result is consumed; the earliest new accept SHALL be the following cycle.
REQ-025 busy SHALL equal (state==CALC).

Reset
REQ-026 rst_n low SHALL immediately force IDLE, counter 0, result 8'h00, rem 4'h0, div_by_zero 0 and out_valid 0, with in_ready 1 and busy 0.
REQ-027 Reset during CALC or DONE SHALL abort the operation, discard the result, and produce no out_valid pulse after release.
REQ-028 The first accept after reset release SHALL be possible at the first rising edge with rst_n high.

Structure
REQ-029 A shared package seq_alu_pkg SHALL hold the opcode constants, the state enum (IDLE/CALC/DONE), the operand width (4), the result width (8) and the iteration count (4).
REQ-030 The iterative mul/div datapath (accumulator, shift register, counter step) SHALL be a sub-module named seq_alu_iter; the FSM, single-cycle ops and handshake SHALL remain in seq_alu_engine.

Verification
REQ-031 Add a=15 b=15, out_ready=1 -> result 8'h1E, out_valid one cycle after accept; sub a=3 b=5 -> 8'hFE.
REQ-032 Mul a=13 b=11 -> busy high 4 cycles, result 8'h8F, rem 0, out_valid at accept+4.
REQ-033 Div a=14 b=3 -> result 8'h04, rem 4'h2, div_by_zero 0 at accept+4; div a=9 b=0 -> result 8'hFF, div_by_zero 1 at latency 1.
REQ-034 Not a=4'h5 -> 8'h0A; out_ready held low 3 cycles -> result stable, in_ready 0, in_valid pulses ignored, IDLE the cycle after out_ready rises.
REQ-035 rst_n pulsed low mid-CALC of mul 15*15 -> out_valid 0 and in_ready 1 during reset, no result after release; next add 1+2 -> 8'h03.
REQ-036 Back-to-back traffic with in_valid held high -> one accept per completed command, never in a cycle with out_valid&out_ready.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU engine: widths, opcodes, FSM
// states and the decode helper that picks the multi-cycle path.
package seq_alu_pkg;

    localparam int OPND_W = 4;
    localparam int RES_W  = 8;
    localparam int ITER_N = 4;
    localparam int CNT_W  = 2;

    localparam logic [CNT_W-1:0] CNT_LAST = 2'd3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_DIV = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Multiply always iterates; divide iterates unless the divisor is zero,
    // which is resolved in a single cycle as a divide-by-zero result.
    function automatic logic is_iter_op(input logic [2:0] op_f,
                                        input logic [OPND_W-1:0] b_f);
        is_iter_op = (op_f == OP_MUL) ||
                     ((op_f == OP_DIV) && (b_f != 4'h0));
    endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// Iterative datapath: shift-add multiply and restoring divide, one step per
// enabled cycle over four iterations. Exposes the next-state values so the
// engine can capture the final result on the last step.
module seq_alu_iter
    import seq_alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic              last,
    output logic [RES_W-1:0]  prod_nxt,
    output logic [OPND_W-1:0] quo_nxt,
    output logic [OPND_W-1:0] rem_nxt
);

    logic [RES_W-1:0]  acc_r;
    logic [RES_W-1:0]  mcand_r;
    logic [OPND_W-1:0] shreg_r;     // multiplier (mul) or dividend/quotient (div)
    logic [OPND_W-1:0] divisor_r;
    logic [OPND_W-1:0] prem_r;      // partial remainder
    logic [CNT_W-1:0]  cnt_r;
    logic              is_div_r;

    logic [RES_W-1:0]  acc_nxt_s;
    logic [OPND_W-1:0] shreg_mul_nxt_s;
    logic [OPND_W-1:0] shreg_div_nxt_s;
    logic [OPND_W-1:0] prem_nxt_s;
    logic [OPND_W:0]   rem_sh_s;
    logic [OPND_W-1:0] diff_s;
    logic              ge_s;

    // One multiply step and one restoring-divide step computed from current state.
    always_comb begin
        if (shreg_r[0]) begin
            acc_nxt_s = acc_r + mcand_r;
        end else begin
            acc_nxt_s = acc_r;
        end
        shreg_mul_nxt_s = {1'b0, shreg_r[OPND_W-1:1]};

        // Bring down the next dividend bit; the subtraction only matters when
        // it does not underflow, so the low four bits of the difference suffice.
        rem_sh_s = {prem_r, shreg_r[OPND_W-1]};
        ge_s     = (rem_sh_s >= {1'b0, divisor_r});
        diff_s   = rem_sh_s[OPND_W-1:0] - divisor_r;
        if (ge_s) begin
            prem_nxt_s = diff_s;
        end else begin
            prem_nxt_s = rem_sh_s[OPND_W-1:0];
        end
        shreg_div_nxt_s = {shreg_r[OPND_W-2:0], ge_s};
    end

    // Operand load on accept, then one iteration per enabled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r     <= 8'h00;
            mcand_r   <= 8'h00;
            shreg_r   <= 4'h0;
            divisor_r <= 4'h0;
            prem_r    <= 4'h0;
            cnt_r     <= 2'd0;
            is_div_r  <= 1'b0;
        end else if (load) begin
            acc_r     <= 8'h00;
            mcand_r   <= {4'h0, a};
            shreg_r   <= is_div ? a : b;
            divisor_r <= b;
            prem_r    <= 4'h0;
            cnt_r     <= 2'd0;
            is_div_r  <= is_div;
        end else if (step) begin
            cnt_r <= cnt_r + 2'd1;
            if (is_div_r) begin
                shreg_r <= shreg_div_nxt_s;
                prem_r  <= prem_nxt_s;
            end else begin
                acc_r   <= acc_nxt_s;
                mcand_r <= {mcand_r[RES_W-2:0], 1'b0};
                shreg_r <= shreg_mul_nxt_s;
            end
        end
    end

    assign last     = (cnt_r == CNT_LAST);
    assign prod_nxt = acc_nxt_s;
    assign quo_nxt  = shreg_div_nxt_s;
    assign rem_nxt  = prem_nxt_s;

endmodule

// File: rtl/seq_alu_engine.sv
// Sequential ALU engine: valid/ready command intake, single-cycle logic and
// arithmetic ops, and a four-step iterative path for multiply and divide.
module seq_alu_engine
    import seq_alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    input  logic [2:0]        op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RES_W-1:0]  result,
    output logic [OPND_W-1:0] rem,
    output logic              div_by_zero,
    output logic              busy
);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [2:0]        op_r;
    logic [RES_W-1:0]  result_r;
    logic [OPND_W-1:0] rem_r;
    logic              dbz_r;

    logic              accept_s;
    logic              iter_op_s;
    logic [RES_W-1:0]  alu_res_s;
    logic              alu_dbz_s;
    logic              iter_last_s;
    logic [RES_W-1:0]  iter_prod_s;
    logic [OPND_W-1:0] iter_quo_s;
    logic [OPND_W-1:0] iter_rem_s;

    assign iter_op_s = is_iter_op(op, b);

    // Next-state and accept decode for the IDLE/CALC/DONE handshake FSM.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    accept_s = 1'b1;
                    if (iter_op_s) begin
                        state_nxt_s = ST_CALC;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (iter_last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_CALC;
                end
            end
            ST_DONE: begin
                // Consuming edge returns to IDLE; no accept in this cycle.
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Single-cycle results; multi-cycle ops leave zero here until they finish.
    always_comb begin
        alu_res_s = 8'h00;
        alu_dbz_s = 1'b0;
        case (op)
            OP_ADD:  alu_res_s = {4'h0, a} + {4'h0, b};
            OP_SUB:  alu_res_s = {4'h0, a} - {4'h0, b};
            OP_AND:  alu_res_s = {4'h0, a & b};
            OP_OR:   alu_res_s = {4'h0, a | b};
            OP_XOR:  alu_res_s = {4'h0, a ^ b};
            OP_NOT:  alu_res_s = {4'h0, ~a};
            OP_DIV: begin
                if (b == 4'h0) begin
                    alu_res_s = 8'hFF;
                    alu_dbz_s = 1'b1;
                end else begin
                    alu_res_s = 8'h00;
                    alu_dbz_s = 1'b0;
                end
            end
            default: alu_res_s = 8'h00;
        endcase
    end

    seq_alu_iter u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept_s),
        .step     (state_r == ST_CALC),
        .is_div   (op == OP_DIV),
        .a        (a),
        .b        (b),
        .last     (iter_last_s),
        .prod_nxt (iter_prod_s),
        .quo_nxt  (iter_quo_s),
        .rem_nxt  (iter_rem_s)
    );

    // State register and result capture at accept or at the final iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            op_r     <= OP_ADD;
            result_r <= 8'h00;
            rem_r    <= 4'h0;
            dbz_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                op_r     <= op;
                result_r <= alu_res_s;
                rem_r    <= 4'h0;
                dbz_r    <= alu_dbz_s;
            end else if ((state_r == ST_CALC) && iter_last_s) begin
                if (op_r == OP_DIV) begin
                    result_r <= {4'h0, iter_quo_s};
                    rem_r    <= iter_rem_s;
                end else begin
                    result_r <= iter_prod_s;
                    rem_r    <= 4'h0;
                end
                dbz_r <= 1'b0;
            end
        end
    end

    assign in_ready    = (state_r == ST_IDLE);
    assign out_valid   = (state_r == ST_DONE);
    assign busy        = (state_r == ST_CALC);
    assign result      = result_r;
    assign rem         = rem_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_alu_engine.sv
// Directed self-checking bench for seq_alu_engine.
module tb_seq_alu_engine;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic [3:0] rem;
    logic       div_by_zero;
    logic       busy;

    int n_checks;
    int n_fail;

    seq_alu_engine dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .op          (op),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .rem         (rem),
        .div_by_zero (div_by_zero),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = 4'h0; b = 4'h0; op = 3'b000;
        #3;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            result !== 8'h00 || rem !== 4'h0 || div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b ov=%b busy=%b res=%h rem=%h dbz=%b, want 1 0 0 00 0 0",
                     in_ready, out_valid, busy, result, rem, div_by_zero);
        end
        step();
        step();
        // Release away from the edge and present a command for the very next edge.
        rst_n = 1'b1;
        in_valid = 1'b1; a = 4'h1; b = 4'h1; op = 3'b000;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || result !== 8'h02) begin
            n_fail++;
            $display("FAIL first_accept: ov=%b res=%h, want 1 02", out_valid, result);
        end
        step();
    endtask

    task automatic test_add_sub();
        logic [3:0] va [2];
        logic [3:0] vb [2];
        logic [2:0] vo [2];
        logic [7:0] ve [2];
        va[0] = 4'd15; vb[0] = 4'd15; vo[0] = 3'b000; ve[0] = 8'h1E;
        va[1] = 4'd3;  vb[1] = 4'd5;  vo[1] = 3'b001; ve[1] = 8'hFE;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; a = va[i]; b = vb[i]; op = vo[i];
            step();
            in_valid = 1'b0;
            n_checks++;
            if (out_valid !== 1'b1 || result !== ve[i] || rem !== 4'h0 ||
                div_by_zero !== 1'b0 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL addsub_%0d: ov=%b res=%h rem=%h dbz=%b rdy=%b, want 1 %h 0 0 0",
                         i, out_valid, result, rem, div_by_zero, in_ready, ve[i]);
            end
            step();
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL addsub_ret_%0d: ov=%b rdy=%b, want 0 1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_logic();
        logic [2:0] vo [4];
        logic [7:0] ve [4];
        vo[0] = 3'b010; ve[0] = 8'h08;   // C & A
        vo[1] = 3'b011; ve[1] = 8'h0E;   // C | A
        vo[2] = 3'b100; ve[2] = 8'h06;   // C ^ A
        vo[3] = 3'b101; ve[3] = 8'h03;   // ~C
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; a = 4'hC; b = 4'hA; op = vo[i];
            step();
            in_valid = 1'b0;
            n_checks++;
            if (out_valid !== 1'b1 || result !== ve[i] || rem !== 4'h0) begin
                n_fail++;
                $display("FAIL logic_%0d: ov=%b res=%h rem=%h, want 1 %h 0",
                         i, out_valid, result, rem, ve[i]);
            end
            step();
        end
    endtask

    task automatic test_mul();
        int busy_cnt;
        out_ready = 1'b1;
        in_valid = 1'b1; a = 4'd13; b = 4'd11; op = 3'b110;
        step();
        in_valid = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy === 1'b1 && out_valid === 1'b0) busy_cnt++;
            step();
        end
        n_checks++;
        if (busy_cnt != 4) begin
            n_fail++;
            $display("FAIL mul_busy: busy cycles=%0d, want 4", busy_cnt);
        end
        n_checks++;
        if (out_valid !== 1'b1 || busy !== 1'b0 || result !== 8'h8F ||
            rem !== 4'h0 || div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_result: ov=%b busy=%b res=%h rem=%h dbz=%b, want 1 0 8f 0 0",
                     out_valid, busy, result, rem, div_by_zero);
        end
        step();
    endtask

    task automatic test_div();
        int busy_cnt;
        out_ready = 1'b1;
        in_valid = 1'b1; a = 4'd14; b = 4'd3; op = 3'b111;
        step();
        in_valid = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy === 1'b1 && out_valid === 1'b0) busy_cnt++;
            step();
        end
        n_checks++;
        if (busy_cnt != 4 || out_valid !== 1'b1 || result !== 8'h04 ||
            rem !== 4'h2 || div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL div_14_3: busy=%0d ov=%b res=%h rem=%h dbz=%b, want 4 1 04 2 0",
                     busy_cnt, out_valid, result, rem, div_by_zero);
        end
        step();
        in_valid = 1'b1; a = 4'd9; b = 4'd0; op = 3'b111;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || result !== 8'hFF || rem !== 4'h0 || div_by_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL div_by_zero: ov=%b res=%h rem=%h dbz=%b, want 1 ff 0 1",
                     out_valid, result, rem, div_by_zero);
        end
        step();
        in_valid = 1'b1; a = 4'd15; b = 4'd1; op = 3'b111;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        n_checks++;
        if (out_valid !== 1'b1 || result !== 8'h0F || rem !== 4'h0 || div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL div_15_1: ov=%b res=%h rem=%h dbz=%b, want 1 0f 0 0",
                     out_valid, result, rem, div_by_zero);
        end
        step();
    endtask

    task automatic test_not_hold();
        out_ready = 1'b0;
        in_valid = 1'b1; a = 4'h5; b = 4'h0; op = 3'b101;
        step();
        for (int i = 0; i < 3; i++) begin
            in_valid = (i != 1); a = 4'h9; b = 4'h9; op = 3'b000;
            n_checks++;
            if (out_valid !== 1'b1 || result !== 8'h0A || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL not_hold_%0d: ov=%b res=%h rdy=%b, want 1 0a 0",
                         i, out_valid, result, in_ready);
            end
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (out_valid !== 1'b1 || result !== 8'h0A) begin
            n_fail++;
            $display("FAIL not_final: ov=%b res=%h, want 1 0a", out_valid, result);
        end
        step();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL not_release: rdy=%b ov=%b, want 1 0", in_ready, out_valid);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL not_ghost: ov=%b, want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_calc();
        int ov_seen;
        out_ready = 1'b1;
        in_valid = 1'b1; a = 4'd15; b = 4'd15; op = 3'b110;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || result !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid: ov=%b rdy=%b busy=%b res=%h, want 0 1 0 00",
                     out_valid, in_ready, busy, result);
        end
        step();
        rst_n = 1'b1;
        ov_seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_valid === 1'b1) ov_seen++;
        end
        n_checks++;
        if (ov_seen != 0) begin
            n_fail++;
            $display("FAIL reset_no_result: out_valid cycles=%0d, want 0", ov_seen);
        end
        in_valid = 1'b1; a = 4'd1; b = 4'd2; op = 3'b000;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || result !== 8'h03) begin
            n_fail++;
            $display("FAIL reset_after_add: ov=%b res=%h, want 1 03", out_valid, result);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [3:0] ca [4];
        logic [3:0] cb [4];
        logic [2:0] co [4];
        logic [7:0] ce [4];
        logic [3:0] cr [4];
        int n_acc;
        int n_done;
        int overlap;
        ca[0] = 4'd2;  cb[0] = 4'd3; co[0] = 3'b000; ce[0] = 8'h05; cr[0] = 4'h0;
        ca[1] = 4'd3;  cb[1] = 4'd4; co[1] = 3'b110; ce[1] = 8'h0C; cr[1] = 4'h0;
        ca[2] = 4'd15; cb[2] = 4'd4; co[2] = 3'b111; ce[2] = 8'h03; cr[2] = 4'h3;
        ca[3] = 4'd5;  cb[3] = 4'd3; co[3] = 3'b100; ce[3] = 8'h06; cr[3] = 4'h0;
        n_acc = 0; n_done = 0; overlap = 0;
        out_ready = 1'b1;
        in_valid = 1'b1; a = ca[0]; b = cb[0]; op = co[0];
        for (int cyc = 0; cyc < 60 && n_done < 4; cyc++) begin
            if (in_ready === 1'b1 && out_valid === 1'b1) overlap++;
            if (out_valid === 1'b1 && n_done < 4) begin
                n_checks++;
                if (result !== ce[n_done] || rem !== cr[n_done]) begin
                    n_fail++;
                    $display("FAIL b2b_result_%0d: res=%h rem=%h, want %h %h",
                             n_done, result, rem, ce[n_done], cr[n_done]);
                end
                n_done++;
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) begin
                n_acc++;
                step();
                if (n_acc < 4) begin
                    a = ca[n_acc]; b = cb[n_acc]; op = co[n_acc];
                end else begin
                    in_valid = 1'b0;
                end
            end else begin
                step();
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (n_acc != 4 || n_done != 4) begin
            n_fail++;
            $display("FAIL b2b_count: accepts=%0d completions=%0d, want 4 4", n_acc, n_done);
        end
        n_checks++;
        if (overlap != 0) begin
            n_fail++;
            $display("FAIL b2b_overlap: ready-with-valid cycles=%0d, want 0", overlap);
        end
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_add_sub();
        test_logic();
        test_mul();
        test_div();
        test_not_hold();
        test_reset_mid_calc();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
